// File: rtl/uart_hex_rx.sv
// uart_hex_rx: 8N1 UART receiver with 16x oversampling that decodes ASCII hex
// characters into 4-bit values and holds the latest one until the consumer pops it.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on the synchronised input
// START | counting to the middle of the start bit, rejecting glitches
// DATA  | sampling DBIT data bits, LSB first, once per 16 ticks
// STOP  | waiting for the stop-bit sample point, then reporting the frame
module uart_hex_rx #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR     = 163,
  parameter int DVSR_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  input  logic       rd_nib,
  output logic [3:0] nib_data,
  output logic       nib_valid,
  output logic       char_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int NW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [NW-1:0]       n_q, n_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DBIT-1:0]     b_q, b_d;
  logic                rx_meta, rx_s;
  logic [DVSR_BIT-1:0] tick_cnt;
  logic                s_tick;
  logic                done;
  logic [7:0]          ch;
  logic                is_hex;
  logic [3:0]          hex_val;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  assign s_tick = (tick_cnt == DVSR_BIT'(DVSR - 1));

  // Free-running oversample tick divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       tick_cnt <= '0;
    else if (s_tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 1'b1;
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      bit_q   <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      bit_q   <= bit_d;
      b_q     <= b_d;
    end
  end

  // Next-state and datapath update; advances only on oversample ticks except idle exit
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    bit_d   = bit_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          n_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (n_q == NW'(7)) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              n_d     = '0;
              bit_d   = '0;
            end
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (n_q == NW'(15)) begin
            n_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (bit_q == BW'(DBIT - 1)) state_d = STOP;
            else                        bit_d   = bit_q + 1'b1;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (n_q == NW'(SB_TICK - 1)) state_d = IDLE;
          else                         n_d     = n_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame completion strobe: the stop-bit sample point is this very cycle
  always_comb begin
    done = 1'b0;
    if (state_q == STOP && s_tick && n_q == NW'(SB_TICK - 1)) done = 1'b1;
  end

  assign ch = b_q[7:0];

  // ASCII hex decode of the assembled byte
  always_comb begin
    is_hex  = 1'b0;
    hex_val = ch[3:0];
    if (ch >= 8'h30 && ch <= 8'h39) begin
      is_hex = 1'b1;
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      is_hex  = 1'b1;
      hex_val = ch[3:0] + 4'd9;
    end
  end

  // Holding register and one-cycle error pulses; a load in the pop cycle keeps valid high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nib_data  <= '0;
      nib_valid <= 1'b0;
      char_err  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      char_err  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rd_nib && nib_valid) nib_valid <= 1'b0;
      if (done) begin
        if (!rx_s) begin
          frame_err <= 1'b1;
        end else if (is_hex) begin
          nib_data  <= hex_val;
          nib_valid <= 1'b1;
          if (nib_valid && !rd_nib) overrun <= 1'b1;
        end else begin
          char_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_hex_rx.sv
// tb_uart_hex_rx: directed frames with hand-computed nibble values and error pulse counts.
module tb_uart_hex_rx;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic       rd_nib;
  logic [3:0] nib_data;
  logic       nib_valid;
  logic       char_err;
  logic       frame_err;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int c_char  = 0;
  int c_frame = 0;
  int c_ovr   = 0;
  int c_wide  = 0;
  logic p_char = 1'b0, p_frame = 1'b0, p_ovr = 1'b0;

  uart_hex_rx #(.DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_BIT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .rd_nib    (rd_nib),
    .nib_data  (nib_data),
    .nib_valid (nib_valid),
    .char_err  (char_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Count error pulses and any pulse lasting more than one cycle
  always @(negedge clk) begin
    if (char_err)  c_char++;
    if (frame_err) c_frame++;
    if (overrun)   c_ovr++;
    if ((char_err && p_char) || (frame_err && p_frame) || (overrun && p_ovr)) c_wide++;
    p_char  = char_err;
    p_frame = frame_err;
    p_ovr   = overrun;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    c_char  = 0;
    c_frame = 0;
    c_ovr   = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    uart_rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    if (good_stop) begin
      uart_rx = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
    end else begin
      uart_rx = 1'b0;
      repeat (48) @(negedge clk);
      uart_rx = 1'b1;
      repeat (16) @(negedge clk);
    end
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic pop();
    rd_nib = 1'b1;
    @(negedge clk);
    rd_nib = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit hit;
    reset   = 1'b1;
    uart_rx = 1'b1;
    rd_nib  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(nib_data), 32'h0);
    chk("rst_valid", 32'(nib_valid), 32'h0);
    chk("rst_errs", 32'({char_err, frame_err, overrun}), 32'h0);
    reset = 1'b0;
    repeat (100) @(negedge clk);

    // 1: 'A'
    clr_cnt();
    send_byte(8'h41, 1'b1);
    chk("A_data", 32'(nib_data), 32'hA);
    chk("A_valid", 32'(nib_valid), 32'h1);
    chk("A_errs", 32'(c_char + c_frame + c_ovr), 32'h0);
    pop();
    chk("A_pop_valid", 32'(nib_valid), 32'h0);

    // 2: '7' then 'f' with a pop between
    clr_cnt();
    send_byte(8'h37, 1'b1);
    chk("7_data", 32'(nib_data), 32'h7);
    chk("7_valid", 32'(nib_valid), 32'h1);
    pop();
    send_byte(8'h66, 1'b1);
    chk("f_data", 32'(nib_data), 32'hF);
    chk("f_valid", 32'(nib_valid), 32'h1);
    chk("7f_ovr", 32'(c_ovr), 32'h0);
    pop();

    // 3: 'g' is not hex
    clr_cnt();
    send_byte(8'h67, 1'b1);
    chk("g_char_err", 32'(c_char), 32'h1);
    chk("g_valid", 32'(nib_valid), 32'h0);
    chk("g_data", 32'(nib_data), 32'hF);
    chk("g_frame_err", 32'(c_frame), 32'h0);

    // 4: '5' with stop bit low
    clr_cnt();
    send_byte(8'h35, 1'b0);
    chk("bs_frame_err", 32'(c_frame), 32'h1);
    chk("bs_valid", 32'(nib_valid), 32'h0);
    chk("bs_data", 32'(nib_data), 32'hF);
    chk("bs_char_err", 32'(c_char), 32'h0);

    // 5: '1','2' without pops -> overrun on second
    clr_cnt();
    send_byte(8'h31, 1'b1);
    chk("1_ovr", 32'(c_ovr), 32'h0);
    send_byte(8'h32, 1'b1);
    chk("12_ovr", 32'(c_ovr), 32'h1);
    chk("12_data", 32'(nib_data), 32'h2);
    chk("12_valid", 32'(nib_valid), 32'h1);
    // repeat: '1' overruns the unread '2', then '2' is popped in its load cycle
    clr_cnt();
    send_byte(8'h31, 1'b1);
    chk("r1_ovr", 32'(c_ovr), 32'h1);
    chk("r1_data", 32'(nib_data), 32'h1);
    clr_cnt();
    hit = 1'b0;
    fork
      send_byte(8'h32, 1'b1);
      begin
        for (int i = 0; i < 2000; i++) begin
          @(negedge clk);
          if (dut.done) begin
            rd_nib = 1'b1;
            hit    = 1'b1;
            break;
          end
        end
        @(negedge clk);
        rd_nib = 1'b0;
      end
    join
    chk("r2_done_seen", 32'(hit), 32'h1);
    chk("r2_ovr", 32'(c_ovr), 32'h0);
    chk("r2_data", 32'(nib_data), 32'h2);
    chk("r2_valid", 32'(nib_valid), 32'h1);
    chk("wide_pulses", 32'(c_wide), 32'h0);

    // 6: glitch of 3 ticks
    clr_cnt();
    uart_rx = 1'b0;
    repeat (12) @(negedge clk);
    uart_rx = 1'b1;
    repeat (800) @(negedge clk);
    chk("gl_errs", 32'(c_char + c_frame + c_ovr), 32'h0);
    chk("gl_data", 32'(nib_data), 32'h2);
    chk("gl_valid", 32'(nib_valid), 32'h1);

    // reset in the middle of data bit 3 of '9' (0x39: bits 1,0,0,1,...)
    uart_rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    uart_rx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    uart_rx = 1'b0;
    repeat (2 * BIT_CLK) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("mr_data", 32'(nib_data), 32'h0);
    chk("mr_valid", 32'(nib_valid), 32'h0);
    reset = 1'b0;
    clr_cnt();
    repeat (800) @(negedge clk);
    chk("mr_after_valid", 32'(nib_valid), 32'h0);
    chk("mr_after_errs", 32'(c_char + c_frame + c_ovr), 32'h0);
    send_byte(8'h43, 1'b1);
    chk("C_data", 32'(nib_data), 32'hC);
    chk("C_valid", 32'(nib_valid), 32'h1);
    chk("C_errs", 32'(c_char + c_frame + c_ovr), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
